run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Processor run-control responder for the start/halt launch protocol driven by the host bench.
//  Holds the core in reset while start=1, launches execution when start falls, and freezes the core on a halt instruction.
//  Raises the halt done flag and keeps it high until the next start.
//  Counts executed cycles, captures the halt PC and enforces a watchdog.
//  Sits inside TopLevel between the instruction decoder and the PC/reg_file/data_mem write enables.
// PARAMETERS
//  PC_W        10    width of program counter / captured halt PC
//  CNT_W       16    width of cycle counter (saturating)
//  WDOG_CYCLES 4096  RUN cycles before forced stop; 0 disables watchdog
// PORTS
//  CLK         in   1      system clock, rising edge
//  Reset       in   1      asynchronous, active-high reset
//  start       in   1      host launch: 1 = hold/arm, 1->0 = launch
//  halt_req    in   1      decoder: current instruction is the halt opcode
//  pc_in       in   PC_W   current PC from PC unit
//  pc_reset    out  1      clears PC to 0
//  pc_en       out  1      PC may advance this cycle
//  wr_inhibit  out  1      1 blocks reg_file and data_mem writes
//  busy        out  1      1 while in RUN
//  halt        out  1      done flag to host (registered)
//  timeout     out  1      stop was caused by the watchdog
//  cycle_cnt   out  CNT_W  RUN cycles executed in the last/current run
//  halt_pc     out  PC_W   PC at which execution stopped
// BEHAVIOUR
//  States: IDLE, ARMED, RUN, DONE. One state register; async Reset forces IDLE.
//  Reset values: state=IDLE, pc_reset=1, pc_en=0, wr_inhibit=1, busy=0, halt=0, timeout=0,
//    cycle_cnt=0, halt_pc=0.
//  IDLE: pc_reset=1. start=1 -> ARMED. start=0 -> stay IDLE (start must be seen high before a launch).
//  ARMED: pc_reset=1, wr_inhibit=1. cycle_cnt, timeout and halt are cleared on entry.
//    start=0 -> RUN at the next edge.
//  RUN: pc_reset=0, busy=1, cycle_cnt +1 per cycle, saturating at all-ones (no wrap).
//    - halt_req=0: pc_en=1, wr_inhibit=0.
//    - halt_req=1: combinationally pc_en=0 and wr_inhibit=1 in the same cycle, so the halt instruction has no side effect.
//      Next state DONE; halt_pc<=pc_in; this cycle is still counted.
//    - Watchdog (WDOG_CYCLES!=0): when cycle_cnt==WDOG_CYCLES-1 and halt_req=0, that cycle executes normally.
//      Then -> DONE with timeout<=1 and halt_pc<=pc_in.
//    - start=1: -> ARMED; has priority over halt_req and watchdog. No halt, no timeout.
//  DONE: halt=1 from the first cycle in DONE. pc_en=0, wr_inhibit=1, pc_reset=0.
//    cycle_cnt, halt_pc and timeout hold. start=1 -> ARMED (halt drops 1 cycle later). Otherwise stay.
//  halt and timeout are register outputs. pc_en, wr_inhibit, pc_reset and busy are decoded from state plus halt_req.
//  Launch latency: start sampled 0 at edge k in ARMED -> RUN from edge k; first PC advance at edge k+1.
//  Reset mid-RUN: immediate IDLE, all outputs to reset values regardless of clock.
// TESTING
//  1. Reset=1, then start=1 for 2 clk, then start=0 -> ARMED then RUN. pc_reset=0 and pc_en=1 exactly one edge after start is sampled 0.
//  2. Run 12 cycles, then halt_req=1 at pc_in=0x00C -> halt=1 next edge. halt_pc=0x00C, cycle_cnt=13, timeout=0.
//     wr_inhibit=1 during the halt cycle; PC frozen.
//  3. WDOG_CYCLES=8, halt_req held 0 -> DONE after 8 RUN cycles. halt=1, timeout=1, cycle_cnt=8.
//  4. start=1 while in DONE -> ARMED. halt=0 and cycle_cnt=0 one edge later.
//     Relaunch and halt after 3 cycles -> cycle_cnt=3.
//  5. start=1 and halt_req=1 in the same RUN cycle -> ARMED, halt stays 0, halt_pc unchanged.
//  6. Assert Reset between edges mid-RUN -> outputs go to reset values before the next CLK edge.
//     CNT_W=4, WDOG=0 long run -> cycle_cnt saturates at 0xF.

Source files
------------

// File: rtl/run_ctrl.sv
// Run-control responder: holds the core in reset while armed, launches on start falling,
// freezes on halt or watchdog expiry, and reports cycle count, halt PC and done status.
module run_ctrl #(
    parameter int          PC_W        = 10,
    parameter int          CNT_W       = 16,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_halt_req,
    input  logic [PC_W-1:0]  i_pc_in,
    output logic             o_pc_reset,
    output logic             o_pc_en,
    output logic             o_wr_inhibit,
    output logic             o_busy,
    output logic             o_halt,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [PC_W-1:0]  o_halt_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned WD_LAST = (WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_halt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [PC_W-1:0]   r_halt_pc;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_wdog_hit;

    assign w_cnt_inc  = (&r_cycle_cnt) ? r_cycle_cnt
                                       : r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_wdog_hit = (WDOG_CYCLES != 0) && (32'(r_cycle_cnt) == WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Core-facing enables are decoded so a halt instruction is suppressed in its own cycle.
    always_comb begin
        w_state_next = r_state;
        o_pc_reset   = 1'b0;
        o_pc_en      = 1'b0;
        o_wr_inhibit = 1'b1;
        o_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_pc_reset = 1'b1;
                if (i_start) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                o_pc_reset = 1'b1;
                if (!i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                o_busy       = 1'b1;
                o_pc_en      = !i_halt_req;
                o_wr_inhibit = i_halt_req;
                if (i_start) begin
                    w_state_next = S_ARMED;
                end else if (i_halt_req || w_wdog_hit) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_state_next = S_ARMED;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status registers: cleared whenever the controller (re)arms, updated while running.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halt      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
            r_halt_pc   <= '0;
        end else if (w_state_next == S_ARMED) begin
            r_halt      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycle_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cycle_cnt <= w_cnt_inc;
            if (w_state_next == S_DONE) begin
                r_halt    <= 1'b1;
                r_timeout <= !i_halt_req;
                r_halt_pc <= i_pc_in;
            end
        end
    end

    assign o_halt      = r_halt;
    assign o_timeout   = r_timeout;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_halt_pc   = r_halt_pc;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three parameterisations share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hreq;
    logic [9:0] pc;

    always #5 clk = ~clk;

    logic        a_pr, a_pe, a_wi, a_busy, a_halt, a_tmo;
    logic [15:0] a_cnt;
    logic [9:0]  a_hpc;
    logic        b_pr, b_pe, b_wi, b_busy, b_halt, b_tmo;
    logic [15:0] b_cnt;
    logic [9:0]  b_hpc;
    logic        c_pr, c_pe, c_wi, c_busy, c_halt, c_tmo;
    logic [3:0]  c_cnt;
    logic [9:0]  c_hpc;

    run_ctrl #(.PC_W(10), .CNT_W(16), .WDOG_CYCLES(4096)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt_req(hreq), .i_pc_in(pc),
        .o_pc_reset(a_pr), .o_pc_en(a_pe), .o_wr_inhibit(a_wi), .o_busy(a_busy),
        .o_halt(a_halt), .o_timeout(a_tmo), .o_cycle_cnt(a_cnt), .o_halt_pc(a_hpc));

    run_ctrl #(.PC_W(10), .CNT_W(16), .WDOG_CYCLES(8)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt_req(hreq), .i_pc_in(pc),
        .o_pc_reset(b_pr), .o_pc_en(b_pe), .o_wr_inhibit(b_wi), .o_busy(b_busy),
        .o_halt(b_halt), .o_timeout(b_tmo), .o_cycle_cnt(b_cnt), .o_halt_pc(b_hpc));

    run_ctrl #(.PC_W(10), .CNT_W(4), .WDOG_CYCLES(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt_req(hreq), .i_pc_in(pc),
        .o_pc_reset(c_pr), .o_pc_en(c_pe), .o_wr_inhibit(c_wi), .o_busy(c_busy),
        .o_halt(c_halt), .o_timeout(c_tmo), .o_cycle_cnt(c_cnt), .o_halt_pc(c_hpc));

    logic [31:0] act [3];
    assign act[0] = {a_pr, a_pe, a_wi, a_busy, a_halt, a_tmo, a_cnt, a_hpc};
    assign act[1] = {b_pr, b_pe, b_wi, b_busy, b_halt, b_tmo, b_cnt, b_hpc};
    assign act[2] = {c_pr, c_pe, c_wi, c_busy, c_halt, c_tmo, 12'h000, c_cnt, c_hpc};

    localparam logic [31:0] RESET_VEC = 32'hA000_0000;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 waiting, 1 armed, 2 executing, 3 finished.
    int m_ph  [3];
    int m_cnt [3];
    bit m_halt[3];
    bit m_tmo [3];
    int m_hpc [3];
    int m_max [3] = '{65535, 65535, 15};
    int m_wd  [3] = '{4096, 8, 0};

    function automatic logic [31:0] expv(int k, bit h);
        logic pr, pe, wi, bz;
        pr = 1'b0; pe = 1'b0; wi = 1'b1; bz = 1'b0;
        if (m_ph[k] <= 1) begin
            pr = 1'b1;
        end else if (m_ph[k] == 2) begin
            pe = !h; wi = h; bz = 1'b1;
        end
        return {pr, pe, wi, bz, m_halt[k], m_tmo[k], 16'(m_cnt[k]), 10'(m_hpc[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ph[k] = 0; m_cnt[k] = 0; m_halt[k] = 0; m_tmo[k] = 0; m_hpc[k] = 0;
        end
    endtask

    task automatic model_edge(bit s, bit h, int p);
        for (int k = 0; k < 3; k++) begin
            int old;
            old = m_cnt[k];
            if (m_ph[k] == 2 && !s) begin
                m_cnt[k] = (old < m_max[k]) ? old + 1 : old;
                if (h) begin
                    m_ph[k] = 3; m_halt[k] = 1; m_hpc[k] = p;
                end else if (m_wd[k] != 0 && old == m_wd[k] - 1) begin
                    m_ph[k] = 3; m_halt[k] = 1; m_tmo[k] = 1; m_hpc[k] = p;
                end
            end else if (s || m_ph[k] == 1) begin
                m_cnt[k] = 0; m_halt[k] = 0; m_tmo[k] = 0;
                m_ph[k] = s ? 1 : (m_ph[k] == 1 ? 2 : m_ph[k]);
            end
        end
    endtask

    task automatic drive(bit s, bit h, logic [9:0] p);
        @(negedge clk);
        start = s; hreq = h; pc = p;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(start, hreq, int'(pc));
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hreq = 1'b0; pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== RESET_VEC) begin
                failures++;
                $display("FAIL reset dut%0d: got %h want %h", k, act[k], RESET_VEC);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_launch();
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 1'b0, 10'd0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL launch dut%0d step%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 10'd1);
        checks++;
        if ({a_pr, a_pe} !== 2'b01) begin
            failures++;
            $display("FAIL launch_latency: got pc_reset,pc_en=%b want 01", {a_pr, a_pe});
        end
        tick();
    endtask

    task automatic test_halt();
        for (int i = 2; i <= 12; i++) begin
            drive(1'b0, 1'b0, 10'(i));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL run dut%0d cyc%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
        drive(1'b0, 1'b1, 10'h00C);
        checks++;
        if ({a_pe, a_wi, a_busy} !== 3'b011) begin
            failures++;
            $display("FAIL halt_cycle: got pc_en,wr_inh,busy=%b want 011", {a_pe, a_wi, a_busy});
        end
        tick();
        drive(1'b0, 1'b0, 10'h00D);
        checks++;
        if ({a_halt, a_tmo, a_cnt, a_hpc} !== {2'b10, 16'd13, 10'h00C}) begin
            failures++;
            $display("FAIL halt_status: got halt=%b tmo=%b cnt=%0d hpc=%h want 1 0 13 00c",
                     a_halt, a_tmo, a_cnt, a_hpc);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== expv(k, hreq)) begin
                failures++;
                $display("FAIL halt_model dut%0d: got %h want %h", k, act[k], expv(k, hreq));
            end
        end
        tick();
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 11; i++) begin
            drive(i == 0, 1'b0, 10'(i + 100));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL wdog dut%0d step%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 10'd0);
        checks++;
        if ({b_halt, b_tmo, b_cnt, b_busy} !== {2'b11, 16'd8, 1'b0}) begin
            failures++;
            $display("FAIL wdog_status: got halt=%b tmo=%b cnt=%0d busy=%b want 1 1 8 0",
                     b_halt, b_tmo, b_cnt, b_busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit s_seq [7] = '{0, 1, 0, 0, 0, 0, 0};
        bit h_seq [7] = '{1, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            drive(s_seq[i], h_seq[i], h_seq[i] ? ((i == 0) ? 10'h055 : 10'h021) : 10'h3A0);
            if (i == 2) begin
                checks++;
                if ({a_halt, a_cnt} !== 17'd0) begin
                    failures++;
                    $display("FAIL rearm_clear: got halt=%b cnt=%0d want 0 0", a_halt, a_cnt);
                end
            end
            if (i == 6) begin
                checks++;
                if ({a_halt, a_cnt, a_hpc} !== {1'b1, 16'd3, 10'h021}) begin
                    failures++;
                    $display("FAIL relaunch: got halt=%b cnt=%0d hpc=%h want 1 3 021", a_halt, a_cnt, a_hpc);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL b2b dut%0d step%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
    endtask

    task automatic test_start_priority();
        for (int i = 0; i < 7; i++) begin
            drive(i == 0 || i >= 5, i == 5, (i == 5) ? 10'h3FF : 10'(i));
            if (i == 6) begin
                checks++;
                if ({a_pr, a_halt, a_tmo, a_hpc} !== {3'b100, 10'h021}) begin
                    failures++;
                    $display("FAIL start_priority: got pc_reset=%b halt=%b tmo=%b hpc=%h want 1 0 0 021",
                             a_pr, a_halt, a_tmo, a_hpc);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL prio dut%0d step%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 1'b0, 10'(i));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL sat dut%0d cyc%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 10'd0);
        checks++;
        if ({c_cnt, c_halt, c_busy} !== {4'hF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL saturate: got cnt=%h halt=%b busy=%b want f 0 1", c_cnt, c_halt, c_busy);
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act[k] !== RESET_VEC) begin
                failures++;
                $display("FAIL reset_midrun dut%0d: got %h want %h", k, act[k], RESET_VEC);
            end
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) == 0, ($urandom % 6) == 0, 10'($urandom));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act[k] !== expv(k, hreq)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", k, i, act[k], expv(k, hreq));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_halt();
        test_watchdog();
        test_back_to_back();
        test_start_priority();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
